fetch_queue: RTL
================

// Module: fetch_queue
// PURPOSE
//   Instruction fetch queue between the ifu and the decode/control stage.
//   - Buffers up to DEPTH {instr, pcadd4} pairs so fetch can run ahead of a
//     stalled decode.
//   - Presents the oldest entry to decode.
//   - flush (taken branch, jump or jr redirect) discards all buffered
//     wrong-path instructions.
// PARAMETERS
//   DEPTH  4  number of entries; power of two, >= 2
//   AW     2  pointer width, log2(DEPTH)
// PORTS
//   clk         in   1   clock, all state updates on posedge
//   rst         in   1   synchronous reset, active-high
//   flush       in   1   discard all entries this cycle
//   in_valid    in   1   ifu offers in_instr/in_pcadd4
//   in_instr    in   32  fetched instruction word
//   in_pcadd4   in   32  PC+4 of fetched instruction
//   in_ready    out  1   queue accepts a push this cycle
//   out_valid   out  1   head entry valid
//   out_instr   out  32  head instruction (32'h0 when empty)
//   out_pcadd4  out  32  head PC+4 (32'h0 when empty)
//   out_pc      out  32  out_pcadd4 - 4 (32'h0 when empty)
//   out_ready   in   1   decode consumes head this cycle
//   level       out  AW+1  number of valid entries, 0..DEPTH
// BEHAVIOUR
//   Storage
//     - Circular buffer of DEPTH x 64 bits.
//     - Write pointer wp and read pointer rp, each AW bits; both wrap
//       DEPTH-1 -> 0.
//     - Counter level is AW+1 bits.
//   Reset
//     - rst=1 at posedge: wp=rp=0, level=0.
//     - Outputs then read: out_valid=0, in_ready=1, out_instr/out_pcadd4/
//       out_pc=0.
//     - Storage contents are don't-care.
//     - rst overrides flush, push and pop.
//   Handshake
//     - in_ready  = (level != DEPTH); combinational from level only, never
//       from out_ready.
//     - out_valid = (level != 0).
//     - push = in_valid & in_ready.
//     - pop  = out_valid & out_ready.
//     - in_instr/in_pcadd4 are sampled only on push; out_ready is ignored
//       while empty.
//   Update at posedge (rst=0, flush=0)
//     - push: mem[wp] <= {in_instr,in_pcadd4}; wp <= wp+1.
//     - pop: rp <= rp+1.
//     - level: +1 on push only, -1 on pop only, unchanged on both or neither.
//   Simultaneous push+pop
//     - Legal at any level 1..DEPTH-1.
//     - At level=DEPTH, push is blocked (in_ready=0); pop proceeds.
//     - At level=0, pop is impossible; push proceeds.
//   Latency
//     - No bypass: a word pushed into an empty queue appears with
//       out_valid=1 in the next cycle.
//     - Back-to-back push/pop sustains 1 instr/cycle.
//   Flush
//     - flush=1 at posedge: wp=rp=0, level=0.
//     - Any push or pop in the same cycle is discarded/ignored.
//     - Next cycle: out_valid=0, in_ready=1.
//   Outputs
//     - Combinational from mem[rp] when level!=0; otherwise forced to 0.
//     - Empty queue therefore shows nop (sll $0,$0,0).
//     - out_pc = out_pcadd4 - 32'd4, modulo 2^32.
//   Ordering
//     - Strict FIFO; no entry duplicated or lost except by flush or rst.
// TESTING
//   1. rst=1 one cycle -> level=0, out_valid=0, in_ready=1,
//      out_instr=0, out_pc=0.
//   2. Push 32'h3c010001 / pcadd4 32'h3004, out_ready=0
//      -> next cycle: out_valid=1, out_instr=32'h3c010001, out_pc=32'h3000,
//      level=1.
//   3. Push 4 words, out_ready=0 -> level=4, in_ready=0.
//      A 5th push with in_valid=1 is dropped.
//      Pop 4 -> words exit in order, level=0.
//   4. level=2, push and pop in the same cycle -> level stays 2.
//      Head advances to the 2nd word.
//      Repeat 2*DEPTH cycles so wp/rp wrap; order preserved.
//   5. level=3, flush=1 with in_valid=1 and out_ready=1 -> next cycle:
//      level=0, out_valid=0, out_instr=0.
//      Pushed word absent.
//   6. flush=1 and rst=1 with push mid-stream -> reset state.
//      A subsequent push of 32'h08000c00 is the first word out.

Source files
------------

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Instruction fetch queue that sits between the ifu and the decode/control
//   stage. It buffers up to DEPTH {instr, pcadd4} pairs, so fetch can keep
//   running while decode is stalled. The oldest entry is always presented to
//   decode. A flush (taken branch, jump or jr redirect) discards every
//   buffered wrong-path instruction.
//
// Parameters
//   DEPTH       number of entries (power of two, >= 2)
//   AW          pointer width, log2(DEPTH)
//
// Ports
//   clk         clock; all state updates on posedge
//   rst         synchronous active-high reset; overrides flush/push/pop
//   flush       empty the queue this cycle; a same-cycle push/pop is dropped
//   in_valid    ifu offers in_instr/in_pcadd4
//   in_instr    fetched instruction word
//   in_pcadd4   PC+4 of the fetched instruction
//   in_ready    queue can accept a push (depends on level only)
//   out_valid   head entry is valid
//   out_instr   head instruction (0, i.e. a nop, when empty)
//   out_pcadd4  head PC+4 (0 when empty)
//   out_pc      head PC = out_pcadd4 - 4 (0 when empty)
//   out_ready   decode consumes the head this cycle
//   level       number of valid entries, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [31:0]   in_instr,
  input  logic [31:0]   in_pcadd4,
  output logic          in_ready,
  output logic          out_valid,
  output logic [31:0]   out_instr,
  output logic [31:0]   out_pcadd4,
  output logic [31:0]   out_pc,
  input  logic          out_ready,
  output logic [AW:0]   level
);

  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ZERO = (AW+1)'(0);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ZERO = AW'(0);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [63:0]   mem_r [DEPTH];
  logic [AW-1:0] wp_r;
  logic [AW-1:0] rp_r;
  logic [AW:0]   level_r;

  logic          push_s;
  logic          pop_s;
  logic [63:0]   head_s;

  // Handshake: in_ready looks only at level so it never depends on out_ready.
  always_comb begin
    in_ready  = (level_r != LVL_FULL);
    out_valid = (level_r != LVL_ZERO);
    push_s    = in_valid & in_ready;
    pop_s     = out_valid & out_ready;
    level     = level_r;
  end

  // Pointer and occupancy state; rst and flush both return to empty.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp_r    <= PTR_ZERO;
      rp_r    <= PTR_ZERO;
      level_r <= LVL_ZERO;
    end else begin
      if (push_s) begin
        wp_r <= wp_r + PTR_ONE;
      end else begin
        wp_r <= wp_r;
      end
      if (pop_s) begin
        rp_r <= rp_r + PTR_ONE;
      end else begin
        rp_r <= rp_r;
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LVL_ONE;
        2'b01:   level_r <= level_r - LVL_ONE;
        default: level_r <= level_r;
      endcase
    end
  end

  // Storage write; contents need no reset because level gates the outputs.
  always_ff @(posedge clk) begin
    if (push_s && !rst && !flush) begin
      mem_r[wp_r] <= {in_instr, in_pcadd4};
    end
  end

  // Head presentation; an empty queue reads as all zeros (sll $0,$0,0).
  always_comb begin
    head_s = mem_r[rp_r];
    if (out_valid) begin
      out_instr  = head_s[63:32];
      out_pcadd4 = head_s[31:0];
      out_pc     = head_s[31:0] - 32'd4;
    end else begin
      out_instr  = 32'h0000_0000;
      out_pcadd4 = 32'h0000_0000;
      out_pc     = 32'h0000_0000;
    end
  end

endmodule
